// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions: write-back source selects, load types, reset PC.
// No logic, so there is no latency.
// No flow control; constants and types only.
package cpu_defs;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Write-back source select
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2,
        WB_SEL_RSV  = 2'd3
    } wb_sel_e;

    // Load types; encodings 5..7 are reserved and behave like a word load
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage inputs and WB-stage outputs of the write-back stage, grouped as one bus.
// Wires only, so there is no latency.
// No backpressure on the bus; stall and flush are the pipeline controls.
interface wb_stage_if;
    // pipeline control
    logic        stall;
    logic        flush;
    // MEM-stage entry
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_dm_rdata;
    logic [2:0]  mem_ld_type;
    // register-file write port
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    // forwarding source for the hazard unit
    logic        fwd_valid;
    logic [4:0]  fwd_wa;
    logic [31:0] fwd_wd;
    // status
    logic        exc_misalign;
    logic [31:0] retire_cnt;

    // pipeline side that drives the MEM-stage entry
    modport master (
        output stall, flush, mem_valid, mem_pc, mem_we, mem_wa, mem_wb_sel,
               mem_alu_res, mem_dm_rdata, mem_ld_type,
        input  grf_we, grf_wa, grf_wd, grf_pc, fwd_valid, fwd_wa, fwd_wd,
               exc_misalign, retire_cnt
    );

    // the write-back stage itself
    modport slave (
        input  stall, flush, mem_valid, mem_pc, mem_we, mem_wa, mem_wb_sel,
               mem_alu_res, mem_dm_rdata, mem_ld_type,
        output grf_we, grf_wa, grf_wd, grf_pc, fwd_valid, fwd_wa, fwd_wd,
               exc_misalign, retire_cnt
    );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Load-data extraction: picks the addressed word/half/byte and sign/zero extends it.
// Purely combinational, zero latency.
// No flow control; also flags misaligned word/halfword loads.
module load_ext
    import cpu_defs::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    // Little-endian lane selection from the byte offset
    always_comb begin
        half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    // Extension and alignment check; reserved types fall into the word case
    always_comb begin
        data_o     = rdata_i;
        misalign_o = (off_i != 2'b00);
        case (ld_type_i)
            LD_H: begin
                data_o     = {{16{half[15]}}, half};
                misalign_o = off_i[0];
            end
            LD_HU: begin
                data_o     = {16'h0000, half};
                misalign_o = off_i[0];
            end
            LD_B: begin
                data_o     = {{24{byte_sel[7]}}, byte_sel};
                misalign_o = 1'b0;
            end
            LD_BU: begin
                data_o     = {24'h00_0000, byte_sel};
                misalign_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus write-back mux driving the GPR write port and WB forwarding.
// One cycle from MEM inputs to grf_*/fwd_* outputs; outputs are combinational from the register.
// stall holds the entry, flush (priority) inserts a bubble; WB_RETIRE_CNT_EN adds a retire counter.
module wb_stage
    import cpu_defs::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    wb_stage_if.slave   bus
);

    logic            valid_q,   valid_d;
    logic            we_q,      we_d;
    logic [4:0]      wa_q,      wa_d;
    wb_sel_e         wb_sel_q,  wb_sel_d;
    logic [XLEN-1:0] alu_q,     alu_d;
    logic [XLEN-1:0] rdata_q,   rdata_d;
    logic [2:0]      ld_type_q, ld_type_d;
    logic [XLEN-1:0] pc_q,      pc_d;

    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;
    logic            misalign_kill;
    logic [XLEN-1:0] wd;
    logic            we_out;

    // Next entry: flush turns the slot into a bubble, stall holds, otherwise capture
    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        wa_d      = wa_q;
        wb_sel_d  = wb_sel_q;
        alu_d     = alu_q;
        rdata_d   = rdata_q;
        ld_type_d = ld_type_q;
        pc_d      = pc_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (!bus.stall) begin
            valid_d   = bus.mem_valid;
            we_d      = bus.mem_we;
            wa_d      = bus.mem_wa;
            wb_sel_d  = wb_sel_e'(bus.mem_wb_sel);
            alu_d     = bus.mem_alu_res;
            rdata_d   = bus.mem_dm_rdata;
            ld_type_d = bus.mem_ld_type;
            pc_d      = bus.mem_pc;
        end
    end

    // MEM/WB register; reset drops any in-flight entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            wa_q      <= 5'd0;
            wb_sel_q  <= WB_SEL_ALU;
            alu_q     <= '0;
            rdata_q   <= '0;
            ld_type_q <= LD_W;
            pc_q      <= RESET_PC;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wb_sel_q  <= wb_sel_d;
            alu_q     <= alu_d;
            rdata_q   <= rdata_d;
            ld_type_q <= ld_type_d;
            pc_q      <= pc_d;
        end
    end

    load_ext u_load_ext (
        .rdata_i    (rdata_q),
        .off_i      (alu_q[1:0]),
        .ld_type_i  (ld_type_q),
        .data_o     (ld_data),
        .misalign_o (ld_misalign)
    );

    // Alignment only matters when the load result is actually consumed
    assign misalign_kill = valid_q & (wb_sel_q == WB_SEL_MEM) & ld_misalign;

    // Write-back data select; driven even when the write is suppressed
    always_comb begin
        wd = '0;
        case (wb_sel_q)
            WB_SEL_ALU:  wd = alu_q;
            WB_SEL_MEM:  wd = ld_data;
            WB_SEL_LINK: wd = pc_q + 32'd8;
            default:     wd = '0;
        endcase
    end

    // $0 is hardwired, reserved selects never write
    assign we_out = valid_q & we_q & (wa_q != 5'd0) & ~misalign_kill
                  & (wb_sel_q != WB_SEL_RSV);

    assign bus.grf_we       = we_out;
    assign bus.grf_wa       = wa_q;
    assign bus.grf_wd       = wd;
    assign bus.grf_pc       = pc_q;
    assign bus.fwd_valid    = we_out;
    assign bus.fwd_wa       = wa_q;
    assign bus.fwd_wd       = wd;
    assign bus.exc_misalign = misalign_kill;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Count entries leaving WB; bubbles carry valid=0 and are skipped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_q <= 32'd0;
        end else if (valid_q && !bus.stall) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign bus.retire_cnt = retire_q;
`else
    assign bus.retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases then randomized traffic against a reference model.
// Outputs are sampled on the falling edge, one cycle after the inputs are captured.
// Exercises stall/flush, async reset mid-stream and the optional retire counter.
module tb_wb_stage;
    import cpu_defs::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference entry currently held in WB
    bit          m_valid;
    bit          m_we;
    bit [4:0]    m_wa;
    bit [1:0]    m_sel;
    bit [31:0]   m_alu;
    bit [31:0]   m_rdata;
    bit [2:0]    m_ld;
    bit [31:0]   m_pc;
    bit [31:0]   m_ret;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_wa = 0; m_sel = 0;
        m_alu = 0; m_rdata = 0; m_ld = 0; m_pc = 32'h0000_3000; m_ret = 0;
    endtask

    // Expected outputs derived from the load/select rules with plain arithmetic
    task automatic model_outputs(output bit e_we, output bit [31:0] e_wd, output bit e_exc);
        int unsigned off;
        bit [31:0]   val;
        bit          mis;
        off = int'(m_alu[1:0]);
        case (m_ld)
            3'd1, 3'd2: begin
                val = (m_rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (m_ld == 3'd1 && val >= 32'h8000) val = val + 32'hFFFF_0000;
                mis = (off % 2) != 0;
            end
            3'd3, 3'd4: begin
                val = (m_rdata >> (8 * off)) & 32'h0000_00FF;
                if (m_ld == 3'd3 && val >= 32'h80) val = val + 32'hFFFF_FF00;
                mis = 0;
            end
            default: begin
                val = m_rdata;
                mis = off != 0;
            end
        endcase
        e_exc = m_valid && m_sel == 2'd1 && mis;
        case (m_sel)
            2'd0:    e_wd = m_alu;
            2'd1:    e_wd = val;
            2'd2:    e_wd = m_pc + 32'd8;
            default: e_wd = 32'd0;
        endcase
        e_we = m_valid && m_we && m_wa != 0 && !e_exc && m_sel != 2'd3;
    endtask

    task automatic check_all(input string ctx);
        bit        e_we;
        bit [31:0] e_wd;
        bit        e_exc;
        bit [31:0] e_ret;
        model_outputs(e_we, e_wd, e_exc);
`ifdef WB_RETIRE_CNT_EN
        e_ret = m_ret;
`else
        e_ret = 32'd0;
`endif
        chk({ctx, ".grf_we"},       32'(bus.grf_we),       32'(e_we));
        chk({ctx, ".grf_wa"},       32'(bus.grf_wa),       32'(m_wa));
        chk({ctx, ".grf_wd"},       bus.grf_wd,            e_wd);
        chk({ctx, ".grf_pc"},       bus.grf_pc,            m_pc);
        chk({ctx, ".fwd_valid"},    32'(bus.fwd_valid),    32'(e_we));
        chk({ctx, ".fwd_wa"},       32'(bus.fwd_wa),       32'(m_wa));
        chk({ctx, ".fwd_wd"},       bus.fwd_wd,            e_wd);
        chk({ctx, ".exc_misalign"}, 32'(bus.exc_misalign), 32'(e_exc));
        chk({ctx, ".retire_cnt"},   bus.retire_cnt,        e_ret);
    endtask

    // One clock: model captures with the same inputs the DUT sees, then compare on the falling edge
    task automatic cycle(input string ctx);
        @(posedge clk);
        if (m_valid && !bus.stall) m_ret = m_ret + 32'd1;
        if (bus.flush) begin
            m_valid = 0;
            m_we    = 0;
        end else if (!bus.stall) begin
            m_valid = bus.mem_valid;
            m_we    = bus.mem_we;
            m_wa    = bus.mem_wa;
            m_sel   = bus.mem_wb_sel;
            m_alu   = bus.mem_alu_res;
            m_rdata = bus.mem_dm_rdata;
            m_ld    = bus.mem_ld_type;
            m_pc    = bus.mem_pc;
        end
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic set_op(input bit v, input bit [31:0] pc, input bit we, input bit [4:0] wa,
                          input bit [1:0] sel, input bit [31:0] alu, input bit [31:0] rdata,
                          input bit [2:0] ld);
        bus.mem_valid    = v;
        bus.mem_pc       = pc;
        bus.mem_we       = we;
        bus.mem_wa       = wa;
        bus.mem_wb_sel   = sel;
        bus.mem_alu_res  = alu;
        bus.mem_dm_rdata = rdata;
        bus.mem_ld_type  = ld;
    endtask

    task automatic set_random();
        set_op($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, $urandom,
               3'($urandom_range(0, 7)));
    endtask

    initial begin
        bus.stall = 0;
        bus.flush = 0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // reset state
        #12;
        check_all("reset");
        chk("reset.grf_pc_const", bus.grf_pc, 32'h0000_3000);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU write
        set_op(1, 32'h3004, 1, 8, 0, 32'h1234_5678, 0, LD_W);
        cycle("alu");
        chk("alu.we_const", 32'(bus.grf_we), 32'd1);
        chk("alu.wd_const", bus.grf_wd, 32'h1234_5678);

        // load extension on rdata 80FF_7F01
        set_op(1, 32'h3008, 1, 9, 1, 32'h1001, 32'h80FF_7F01, LD_B);
        cycle("lb1");
        chk("lb1.wd_const", bus.grf_wd, 32'h0000_007F);
        set_op(1, 32'h300C, 1, 9, 1, 32'h1003, 32'h80FF_7F01, LD_B);
        cycle("lb3");
        chk("lb3.wd_const", bus.grf_wd, 32'hFFFF_FF80);
        set_op(1, 32'h3010, 1, 9, 1, 32'h1002, 32'h80FF_7F01, LD_BU);
        cycle("lbu2");
        chk("lbu2.wd_const", bus.grf_wd, 32'h0000_00FF);
        set_op(1, 32'h3014, 1, 9, 1, 32'h1002, 32'h80FF_7F01, LD_H);
        cycle("lh2");
        chk("lh2.wd_const", bus.grf_wd, 32'hFFFF_80FF);
        set_op(1, 32'h3018, 1, 9, 1, 32'h1002, 32'h80FF_7F01, LD_HU);
        cycle("lhu2");
        chk("lhu2.wd_const", bus.grf_wd, 32'h0000_80FF);

        // misaligned lw, then write to $0
        set_op(1, 32'h301C, 1, 10, 1, 32'h0000_0102, 32'h80FF_7F01, LD_W);
        cycle("mis");
        chk("mis.exc_const", 32'(bus.exc_misalign), 32'd1);
        chk("mis.we_const", 32'(bus.grf_we), 32'd0);
        set_op(1, 32'h3020, 1, 0, 0, 32'hDEAD_BEEF, 0, LD_W);
        cycle("r0");
        chk("r0.we_const", 32'(bus.grf_we), 32'd0);
        chk("r0.exc_clear", 32'(bus.exc_misalign), 32'd0);

        // link wraps modulo 2^32
        set_op(1, 32'hFFFF_FFFC, 1, 31, 2, 0, 0, LD_W);
        cycle("link");
        chk("link.wd_const", bus.grf_wd, 32'h0000_0004);

        // stall holds outputs while inputs change
        set_op(1, 32'h3030, 1, 5, 0, 32'hCAFE_0001, 0, LD_W);
        cycle("pre_stall");
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_random();
            cycle("stall");
            chk("stall.wd_hold", bus.grf_wd, 32'hCAFE_0001);
            chk("stall.we_hold", 32'(bus.grf_we), 32'd1);
        end

        // stall and flush together: flush wins
        bus.flush = 1;
        set_random();
        cycle("stall_flush");
        chk("stall_flush.we_const", 32'(bus.grf_we), 32'd0);
        bus.stall = 0;
        bus.flush = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            set_random();
            if ($urandom_range(0, 3) == 0) bus.mem_wb_sel = 2'd1;
            cycle("rand");
        end
        bus.stall = 0;
        bus.flush = 0;

        // async reset between edges after a real write
        set_op(1, 32'h4000, 1, 7, 0, 32'h0BAD_F00D, 0, LD_W);
        cycle("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.we_const", 32'(bus.grf_we), 32'd0);
        chk("arst.pc_const", bus.grf_pc, 32'h0000_3000);
        @(posedge clk);
        @(negedge clk);
        check_all("arst_hold");
        reset_n = 1'b1;

        // resumes cleanly after reset
        set_op(1, 32'h3004, 1, 3, 0, 32'h5555_AAAA, 0, LD_W);
        cycle("post_rst");
        set_op(0, 0, 0, 0, 0, 0, 0, LD_W);
        cycle("post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back datapath for the 5-stage MIPS core.
- Captures MEM-stage results, performs load-data extraction and extension, and selects the write-back value.
- Drives the register-file write port (address, data, enable, PC for the write trace).
- Exports the same values as the WB-stage forwarding source to the hazard unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_3000, value loaded into the registered PC at reset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  hold MEM/WB register contents.
- flush  in  1  replace the next captured entry with a bubble.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_pc  in  32  PC of the MEM-stage instruction.
- mem_we  in  1  instruction writes a GPR.
- mem_wa  in  5  destination GPR.
- mem_wb_sel  in  2  write-back source: 0 = ALU, 1 = load, 2 = PC+8 (link), 3 = reserved.
- mem_alu_res  in  32  ALU result; its bits [1:0] are the load byte offset.
- mem_dm_rdata  in  32  raw aligned data-memory word.
- mem_ld_type  in  3  load type: 0 = lw, 1 = lh, 2 = lhu, 3 = lb, 4 = lbu; others reserved.
- grf_we  out  1  register-file write enable.
- grf_wa  out  5  register-file write address.
- grf_wd  out  32  register-file write data.
- grf_pc  out  32  PC of the writing instruction.
- fwd_valid  out  1  WB forwarding source is valid; equals grf_we.
- fwd_wa  out  5  equals grf_wa.
- fwd_wd  out  32  equals grf_wd.
- exc_misalign  out  1  one-cycle pulse: misaligned load detected in WB.
- retire_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Register update: on posedge clk, flush takes priority, then stall. flush=1 clears r_valid and r_we and leaves the other fields unchanged. Otherwise stall=0 captures all mem_* fields. stall=1 holds every field.
- Reset: asserting reset_n=0 immediately clears r_valid, r_we, r_wa, r_wb_sel, r_alu, r_rdata and r_ld_type, and loads r_pc with RESET_PC. Reset mid-operation discards the in-flight entry with no write. Output values at reset:
  - grf_we = 0, grf_wa = 0, grf_wd = 0, grf_pc = RESET_PC.
  - exc_misalign = 0, retire_cnt = 0.
- Latency: exactly one cycle from the MEM-stage inputs to the grf_* and fwd_* outputs. All outputs are combinational from the registered fields, except retire_cnt.
- Load extraction uses off = r_alu[1:0]:
  - lw selects the whole word.
  - lh/lhu select halfword off[1].
  - lb/lbu select byte off. Little-endian: byte 0 = bits [7:0].
  - lh/lb sign-extend; lhu/lbu zero-extend.
- Misalignment: lw with off != 0, or lh/lhu with off[0] = 1.
  - When misaligned and r_valid=1 and r_wb_sel=1: exc_misalign=1 and grf_we is forced to 0.
  - Reserved ld_type is treated as lw.
- Write-back select: wb_sel 0 gives r_alu. 1 gives the extended load data. 2 gives r_pc + 8, modulo 2^32. 3 gives 0 with grf_we forced to 0.
- grf_we = r_valid & r_we & (r_wa != 0) & ~misalign_kill & (r_wb_sel != 3). A write to $0 is never enabled.
- grf_wd is always driven from the select, even when grf_we=0.
- Stall: while stall=1 the outputs stay constant across cycles. The register file may see the same write repeatedly; this is idempotent.
- stall and flush in the same cycle: flush wins, and the next cycle shows a bubble.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt is a 32-bit counter. It increments on each posedge where r_valid=1 and stall=0, i.e. the entry leaves WB. Flushed bubbles are not counted. It wraps from 32'hFFFF_FFFF to 0 and is cleared asynchronously by reset_n.
- Undefined: retire_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Shared package (cpu_defs) holds:
  - WB_SEL_ALU, WB_SEL_MEM, WB_SEL_LINK, WB_SEL_RSV.
  - LD_W, LD_H, LD_HU, LD_B, LD_BU.
  - RESET_PC default.
- One sub-module, load_ext: purely combinational (rdata, off, ld_type) to (data, misalign). It is reused by the later cache-bypass path.

Test Plan:
- Reset then ALU op: reset_n low, release; mem_valid=1, we=1, wa=8, wb_sel=0, alu=32'h1234_5678, pc=32'h3004. Next cycle requires grf_we=1, wa=8, wd=32'h1234_5678, pc=32'h3004, fwd_* equal to grf_*.
- Load extension: rdata=32'h80FF_7F01.
  - lb, off=1: wd=32'h0000_007F.
  - lb, off=3: wd=32'hFFFF_FF80.
  - lbu, off=2: wd=32'h0000_00FF.
  - lh, off=2: wd=32'hFFFF_80FF.
  - lhu, off=2: wd=32'h0000_80FF.
- Misaligned and $0: lw with alu=32'h0000_0102 gives exc_misalign pulse and grf_we=0. An ALU write to wa=0 gives grf_we=0.
- Link: wb_sel=2, pc=32'hFFFF_FFFC gives wd=32'h0000_0004.
- Stall/flush: hold stall=1 for 3 cycles with changing mem_* inputs; the outputs stay unchanged. Assert stall=1 and flush=1 together; the next cycle grf_we=0. If WB_RETIRE_CNT_EN is defined, retire_cnt counts only non-bubble entries that leave WB.
- Async reset mid-stream: drop reset_n between clock edges. grf_we goes to 0 immediately, grf_pc=32'h0000_3000, retire_cnt=0.
